// File: rtl/seq_det_pkg.sv
// Shared definitions for the multi-channel 1011 sequence detector:
// per-channel context encoding and the detected pattern.
package seq_det_pkg;

    localparam int unsigned STATE_W = 2;

    // Context encodes the longest matched prefix of the pattern
    localparam logic [STATE_W-1:0] S0 = 2'b00;
    localparam logic [STATE_W-1:0] S1 = 2'b01;
    localparam logic [STATE_W-1:0] S2 = 2'b10;
    localparam logic [STATE_W-1:0] S3 = 2'b11;

    localparam int unsigned PAT_W = 4;
    localparam logic [PAT_W-1:0] PATTERN = 4'b1011;

endpackage

// File: rtl/seq_det_core.sv
// Combinational next-context and Mealy hit logic for one 1011 detector step;
// shared by all channels through the scheduler.
module seq_det_core
    import seq_det_pkg::*;
(
    input  logic [STATE_W-1:0] state,
    input  logic               din,
    output logic [STATE_W-1:0] next_state,
    output logic               hit
);

    always_comb begin
        next_state = S0;
        hit        = 1'b0;
        case (state)
            S0: next_state = din ? S1 : S0;
            S1: next_state = din ? S1 : S2;
            S2: next_state = din ? S3 : S0;
            S3: begin
                next_state = din ? S1 : S2;
                hit        = (din == PATTERN[0]);
            end
        endcase
    end

endmodule

// File: rtl/seq_det_scheduler.sv
// Round-robin scheduler time-sharing one 1011 detector across NCH serial
// channels, with per-channel contexts, match pulses and saturating counters.
module seq_det_scheduler
    import seq_det_pkg::*;
#(
    parameter  int unsigned NCH   = 4,
    parameter  int unsigned CNT_W = 8,
    localparam int unsigned GID_W = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 soft_clr,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH-1:0]       in_bit,
    output logic [NCH-1:0]       in_ready,
    output logic [NCH-1:0]       match,
    output logic [NCH*CNT_W-1:0] match_cnt,
    output logic [GID_W-1:0]     grant_id,
    output logic                 busy
);

    logic [STATE_W-1:0] ctx [NCH];
    logic [CNT_W-1:0]   cnt [NCH];
    logic [GID_W-1:0]   ptr;
    logic [GID_W-1:0]   cand;
    logic [STATE_W-1:0] cur_state;
    logic [STATE_W-1:0] nxt_state;
    logic               hit;

    // Round-robin search starting just after the last granted channel
    always_comb begin
        in_ready = '0;
        grant_id = '0;
        busy     = 1'b0;
        cand     = '0;
        if (enable && !soft_clr) begin
            for (int unsigned k = 1; k <= NCH; k++) begin
                cand = GID_W'((32'(ptr) + k) % NCH);
                if (!busy && in_valid[cand]) begin
                    busy     = 1'b1;
                    grant_id = cand;
                end
            end
        end
        if (busy) begin
            in_ready[grant_id] = 1'b1;
        end
    end

    assign cur_state = ctx[grant_id];

    seq_det_core u_core (
        .state      (cur_state),
        .din        (in_bit[grant_id]),
        .next_state (nxt_state),
        .hit        (hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                ctx[i] <= S0;
                cnt[i] <= '0;
            end
            match <= '0;
            ptr   <= GID_W'(NCH - 1);
        end else if (soft_clr) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                ctx[i] <= S0;
                cnt[i] <= '0;
            end
            match <= '0;
            ptr   <= GID_W'(NCH - 1);
        end else begin
            match <= '0;
            if (busy) begin
                ctx[grant_id] <= nxt_state;
                ptr           <= grant_id;
                if (hit) begin
                    match[grant_id] <= 1'b1;
                    if (cnt[grant_id] != '1) begin
                        cnt[grant_id] <= cnt[grant_id] + CNT_W'(1);
                    end
                end
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_cnt
        assign match_cnt[i*CNT_W +: CNT_W] = cnt[i];
    end

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Bench for seq_det_scheduler: a bit-history reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_seq_det_scheduler;

    localparam int unsigned NCH   = 4;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned GID_W = 2;
    localparam int          CMAX  = (1 << CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 enable = 1'b0;
    logic                 soft_clr = 1'b0;
    logic [NCH-1:0]       in_valid = '0;
    logic [NCH-1:0]       in_bit = '0;
    logic [NCH-1:0]       in_ready;
    logic [NCH-1:0]       match;
    logic [NCH*CNT_W-1:0] match_cnt;
    logic [GID_W-1:0]     grant_id;
    logic                 busy;

    int n_vec = 0;
    int n_err = 0;

    seq_det_scheduler #(.NCH(NCH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .soft_clr  (soft_clr),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_ready  (in_ready),
        .match     (match),
        .match_cnt (match_cnt),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: last four transferred bits per channel, plain counts
    logic [3:0]     m_hist [NCH];
    int             m_len  [NCH];
    int             m_cnt  [NCH];
    logic [NCH-1:0] m_match;
    int             m_ptr;
    int             pulses [NCH];

    task automatic m_clear();
        for (int c = 0; c < NCH; c++) begin
            m_hist[c] = 4'b0000;
            m_len[c]  = 0;
            m_cnt[c]  = 0;
        end
        m_match = '0;
        m_ptr   = NCH - 1;
    endtask

    initial begin
        m_clear();
        for (int c = 0; c < NCH; c++) pulses[c] = 0;
    end

    always @(negedge clk) begin
        int g;
        logic [NCH-1:0] exp_ready;
        if (rst) m_clear();
        for (int c = 0; c < NCH; c++) begin
            if (match[c] === 1'b1) pulses[c]++;
            chk($sformatf("match[%0d]", c), 64'(match[c]), 64'(m_match[c]));
            chk($sformatf("match_cnt[%0d]", c), 64'(match_cnt[c*CNT_W +: CNT_W]), 64'(m_cnt[c]));
        end
        g = -1;
        if (enable && !soft_clr) begin
            for (int k = 1; k <= NCH; k++) begin
                int c;
                c = (m_ptr + k) % NCH;
                if (g < 0 && in_valid[c]) g = c;
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        chk("in_ready", 64'(in_ready), 64'(exp_ready));
        chk("busy", 64'(busy), 64'(g >= 0));
        if (g >= 0) chk("grant_id", 64'(grant_id), 64'(g));
        if (!rst) begin
            if (soft_clr) begin
                m_clear();
            end else begin
                m_match = '0;
                if (g >= 0) begin
                    m_hist[g] = {m_hist[g][2:0], in_bit[g]};
                    if (m_len[g] < 4) m_len[g]++;
                    if (m_len[g] == 4 && m_hist[g] == 4'b1011) begin
                        m_match[g] = 1'b1;
                        if (m_cnt[g] < CMAX) m_cnt[g]++;
                    end
                    m_ptr = g;
                end
            end
        end
    end

    task automatic drive(input logic [NCH-1:0] v, input logic [NCH-1:0] b,
                         input logic e, input logic s);
        in_valid = v;
        in_bit   = b;
        enable   = e;
        soft_clr = s;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int ch, input logic bv);
        drive(NCH'(1) << ch, NCH'(bv) << ch, 1'b1, 1'b0);
    endtask

    task automatic idle();
        drive('0, '0, 1'b1, 1'b0);
    endtask

    task automatic sclr();
        drive('0, '0, 1'b1, 1'b1);
    endtask

    initial begin
        int p0;
        logic [3:0] pat;
        pat = 4'b1011;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_match", 64'(match), 64'd0);
        chk("reset_cnt", 64'(match_cnt), 64'd0);
        rst = 1'b0;

        // ch0 alone: 1,0,1,1,0,1,1 -> hits after 4th and 7th
        p0 = pulses[0];
        send(0, 1'b1); send(0, 1'b0); send(0, 1'b1); send(0, 1'b1);
        chk("ch0_hit4", 64'(match[0]), 64'd1);
        send(0, 1'b0);
        chk("ch0_pulse_1cyc", 64'(match[0]), 64'd0);
        send(0, 1'b1); send(0, 1'b1);
        chk("ch0_hit7", 64'(match[0]), 64'd1);
        idle();
        chk("ch0_cnt", 64'(match_cnt[0 +: CNT_W]), 64'd2);
        chk("ch0_pulses", 64'(pulses[0] - p0), 64'd2);

        // All valids high: strict rotation 0,1,2,3,0,...
        sclr();
        in_valid = '1; in_bit = '0; enable = 1'b1; soft_clr = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rr_order", 64'(grant_id), 64'(k % 4));
            chk("rr_onehot", 64'(in_ready), 64'(1 << (k % 4)));
            @(posedge clk);
            #1;
        end

        // ch1 prefix interleaved with ch2 zeros, then ch1 completes
        sclr();
        send(1, 1'b1); send(2, 1'b0); send(1, 1'b0); send(2, 1'b0);
        drive(4'b0110, 4'b0010, 1'b1, 1'b0);
        drive(4'b0110, 4'b0000, 1'b1, 1'b0);
        send(1, 1'b1);
        chk("ch1_match", 64'(match[1]), 64'd1);
        chk("ch2_nomatch", 64'(match[2]), 64'd0);
        idle();
        chk("ch1_cnt", 64'(match_cnt[1*CNT_W +: CNT_W]), 64'd1);
        chk("ch2_cnt", 64'(match_cnt[2*CNT_W +: CNT_W]), 64'd0);

        // Saturation: 300 x 1011 on ch2
        sclr();
        for (int r = 0; r < 300; r++) begin
            for (int j = 3; j >= 0; j--) send(2, pat[j]);
        end
        idle();
        chk("ch2_saturate", 64'(match_cnt[2*CNT_W +: CNT_W]), 64'd255);

        // soft_clr coinciding with a completing 4th bit
        sclr();
        send(0, 1'b1); send(0, 1'b0); send(0, 1'b1);
        in_valid = 4'b0001; in_bit = 4'b0001; enable = 1'b1; soft_clr = 1'b1;
        #1;
        chk("sclr_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("sclr_nomatch", 64'(match), 64'd0);
        chk("sclr_cnt", 64'(match_cnt), 64'd0);
        in_valid = '1; in_bit = '0; soft_clr = 1'b0;
        #1;
        chk("sclr_next_grant", 64'(grant_id), 64'd0);
        @(posedge clk);
        #1;

        // enable low blocks all grants
        in_valid = '1; enable = 1'b0;
        #1;
        chk("dis_ready", 64'(in_ready), 64'd0);
        chk("dis_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;

        // Mid-stream reset discards the partial 101 on ch3
        send(3, 1'b1); send(3, 1'b0); send(3, 1'b1);
        rst = 1'b1;
        drive('0, '0, 1'b1, 1'b0);
        rst = 1'b0;
        send(3, 1'b1);
        chk("rst_discard", 64'(match[3]), 64'd0);
        idle();

        // Mixed contention traffic checked against the model
        for (int k = 0; k < 200; k++) begin
            drive(NCH'($urandom), NCH'($urandom), 1'($urandom_range(0, 7) != 0),
                  1'($urandom_range(0, 49) == 0));
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
